// File: rtl/box_map_if.sv
// Tile read port, explosion request bus and status for the box occupancy map.
// The master side is the map client; the slave side is box_map_writer.
interface box_map_if #(
  parameter int CW = 4
);
  logic [CW-1:0] rd_col;
  logic [CW-1:0] rd_row;
  logic          rd_box;
  logic          blast_req;
  logic [CW-1:0] blast_col;
  logic [CW-1:0] blast_row;
  logic [1:0]    blast_range;
  logic          blast_ready;
  logic          blast_done;
  logic [2:0]    cleared_count;
  logic [7:0]    box_count;
  logic          init_done;

  modport master (
    output rd_col, rd_row, blast_req, blast_col, blast_row, blast_range,
    input  rd_box, blast_ready, blast_done, cleared_count, box_count, init_done
  );

  modport slave (
    input  rd_col, rd_row, blast_req, blast_col, blast_row, blast_range,
    output rd_box, blast_ready, blast_done, cleared_count, box_count, init_done
  );
endinterface

// File: rtl/box_map_writer.sv
// Destructible-box occupancy map: builds the initial layout after reset, clears
// boxes along explosion rays, and serves a registered single-tile read port.
module box_map_writer #(
  parameter int GRID_W = 15,
  parameter int GRID_H = 11,
  parameter int CW     = 4
) (
  input  logic     clk,
  input  logic     reset,
  box_map_if.slave bus
);
  localparam int N  = GRID_W * GRID_H;
  localparam int AW = $clog2(N);
  localparam logic [CW:0] GW = (CW+1)'(GRID_W);
  localparam logic [CW:0] GH = (CW+1)'(GRID_H);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CENTER, S_ARM, S_DONE} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  logic map_mem [N];

  state_t        state_reg, state_next;
  dir_t          dir_reg, dir_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [CW-1:0] init_col_reg, init_col_next, init_row_reg, init_row_next;
  logic [CW-1:0] col_reg, col_next, row_reg, row_next;
  logic [1:0]    rng_reg, rng_next, step_reg, step_next;
  logic [2:0]    acc_reg, acc_next, cleared_reg, cleared_next;
  logic [7:0]    box_count_reg, box_count_next;
  logic          init_done_reg, init_done_next;
  logic          rd_box_reg;

  logic          wr_en, wr_data;
  logic [AW-1:0] wr_addr;
  logic [CW:0]   init_diag;
  logic          init_box;
  logic [CW:0]   step_ext, t_col, t_row;
  logic          t_under, t_on_grid, t_pillar, t_box, ray_end;
  logic [AW-1:0] t_addr;
  logic          blast_oob, rd_in_range;
  logic [AW-1:0] rd_addr;

  // Initial layout: no pillars, no spawn corner, and a diagonal gap pattern.
  assign init_diag = {1'b0, init_col_reg} + {1'b0, init_row_reg};
  assign init_box  = !(init_col_reg[0] && init_row_reg[0])
                  && !(init_row_reg == '0 && init_col_reg <= CW'(1))
                  && !(init_col_reg == '0 && init_row_reg == CW'(1))
                  && ((init_diag % (CW+1)'(3)) != '0);

  assign blast_oob = ({1'b0, bus.blast_col} >= GW) || ({1'b0, bus.blast_row} >= GH);
  assign step_ext  = (CW+1)'(step_reg);

  // Tile under inspection: the centre in CENTER, centre +/- step along dir in ARM.
  always_comb begin
    t_col   = {1'b0, col_reg};
    t_row   = {1'b0, row_reg};
    t_under = 1'b0;
    if (state_reg == S_ARM) begin
      case (dir_reg)
        D_UP:    begin t_under = step_ext > {1'b0, row_reg}; t_row = {1'b0, row_reg} - step_ext; end
        D_DOWN:  t_row = {1'b0, row_reg} + step_ext;
        D_LEFT:  begin t_under = step_ext > {1'b0, col_reg}; t_col = {1'b0, col_reg} - step_ext; end
        default: t_col = {1'b0, col_reg} + step_ext;
      endcase
    end
    t_on_grid = !t_under && (t_col < GW) && (t_row < GH);
    t_addr    = t_on_grid ? AW'(int'(t_row) * GRID_W + int'(t_col)) : '0;
    t_pillar  = t_col[0] && t_row[0];
    t_box     = t_on_grid && map_mem[t_addr];
    ray_end   = !t_on_grid || t_pillar || t_box || (step_reg == rng_reg);
  end

  always_comb begin
    state_next     = state_reg;
    dir_next       = dir_reg;
    idx_next       = idx_reg;
    init_col_next  = init_col_reg;
    init_row_next  = init_row_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    rng_next       = rng_reg;
    step_next      = step_reg;
    acc_next       = acc_reg;
    cleared_next   = cleared_reg;
    box_count_next = box_count_reg;
    init_done_next = init_done_reg;
    wr_en          = 1'b0;
    wr_data        = 1'b0;
    wr_addr        = t_addr;
    case (state_reg)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_addr = idx_reg;
        wr_data = init_box;
        if (init_box) box_count_next = box_count_reg + 8'd1;
        idx_next = idx_reg + AW'(1);
        if (init_col_reg == CW'(GRID_W - 1)) begin
          init_col_next = '0;
          init_row_next = init_row_reg + CW'(1);
        end else begin
          init_col_next = init_col_reg + CW'(1);
        end
        if (idx_reg == AW'(N - 1)) begin
          init_done_next = 1'b1;
          state_next     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.blast_req) begin
          col_next   = bus.blast_col;
          row_next   = bus.blast_row;
          rng_next   = (bus.blast_range == 2'd0) ? 2'd1 : bus.blast_range;
          acc_next   = '0;
          state_next = blast_oob ? S_DONE : S_CENTER;
        end
      end
      S_CENTER, S_ARM: begin
        if (t_box) begin
          wr_en          = 1'b1;
          box_count_next = box_count_reg - 8'd1;
          acc_next       = acc_reg + 3'd1;
        end
        if (state_reg == S_CENTER) begin
          dir_next   = D_UP;
          step_next  = 2'd1;
          state_next = S_ARM;
        end else if (ray_end) begin
          step_next = 2'd1;
          case (dir_reg)
            D_UP:    dir_next = D_DOWN;
            D_DOWN:  dir_next = D_LEFT;
            D_LEFT:  dir_next = D_RIGHT;
            default: state_next = S_DONE;
          endcase
        end else begin
          step_next = step_reg + 2'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // The result is published on entry to DONE so it is valid alongside blast_done.
    if (state_next == S_DONE) cleared_next = acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_INIT;
      dir_reg       <= D_UP;
      idx_reg       <= '0;
      init_col_reg  <= '0;
      init_row_reg  <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      rng_reg       <= '0;
      step_reg      <= '0;
      acc_reg       <= '0;
      cleared_reg   <= '0;
      box_count_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      idx_reg       <= idx_next;
      init_col_reg  <= init_col_next;
      init_row_reg  <= init_row_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      rng_reg       <= rng_next;
      step_reg      <= step_next;
      acc_reg       <= acc_next;
      cleared_reg   <= cleared_next;
      box_count_reg <= box_count_next;
      init_done_reg <= init_done_next;
    end
  end

  // Writes are suppressed during reset so an abandoned blast erases nothing more.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) map_mem[wr_addr] <= wr_data;
  end

  assign rd_in_range = ({1'b0, bus.rd_col} < GW) && ({1'b0, bus.rd_row} < GH);
  assign rd_addr     = rd_in_range ? AW'(int'(bus.rd_row) * GRID_W + int'(bus.rd_col)) : '0;

  always_ff @(posedge clk) begin
    if (reset) rd_box_reg <= 1'b0;
    else       rd_box_reg <= rd_in_range && map_mem[rd_addr];
  end

  assign bus.rd_box        = rd_box_reg;
  assign bus.blast_ready   = (state_reg == S_IDLE);
  assign bus.blast_done    = (state_reg == S_DONE);
  assign bus.cleared_count = cleared_reg;
  assign bus.box_count     = box_count_reg;
  assign bus.init_done     = init_done_reg;
endmodule

// File: doc/box_map_writer.md
Name: box_map_writer

Overview:
- Owns the destructible-box occupancy map for the playfield and is the only block that writes it.
- On reset it builds the initial box layout. It then clears boxes when a bomb-explosion request arrives.
- It exposes a registered tile read port. The box renderer and collision logic use this port to decide box_on and blocked directions.

Parameters:
GRID_W, 15, playfield width in tiles (col 0..GRID_W-1)
GRID_H, 11, playfield height in tiles (row 0..GRID_H-1)
CW, 4, tile column/row index width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rd_col  input  CW  read-port tile column
rd_row  input  CW  read-port tile row
rd_box  output  1  box present at (rd_col,rd_row), registered
blast_req  input  1  explosion request, held until accepted
blast_col  input  CW  explosion centre column
blast_row  input  CW  explosion centre row
blast_range  input  2  blast reach in tiles; 0 is treated as 1
blast_ready  output  1  high in IDLE; the request is accepted when blast_req && blast_ready
blast_done  output  1  one-cycle pulse when the explosion has finished processing
cleared_count  output  3  boxes removed by the last explosion, valid with blast_done and held afterwards
box_count  output  8  live boxes remaining
init_done  output  1  high once the initial layout is written

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: blast_ready=0, blast_done=0, cleared_count=0, box_count=0, init_done=0, rd_box=0. The state goes to INIT with tile index 0.
- Map storage: GRID_W*GRID_H bits, index = row*GRID_W+col.
- Pillar tile: col odd AND row odd. A pillar never holds a box and is never written to 1.
- Spawn tiles: (0,0), (1,0), (0,1). These never hold a box.
- Initial layout: box = 1 iff the tile is not a pillar, not a spawn tile, and (col+row) mod 3 != 0.
- INIT state:
  - Writes one tile per cycle in index order 0..GRID_W*GRID_H-1 (165 cycles at default size).
  - Increments box_count for each box written.
  - After the last tile, sets init_done=1 and moves to IDLE.
- IDLE state:
  - blast_ready=1.
  - On accept, latches col/row/range into registers, clears the cleared_count accumulator, and moves to CENTER.
  - blast_ready drops in the cycle after accept.
- Out-of-bounds centre (col>=GRID_W or row>=GRID_H): go straight to DONE with cleared_count=0 and the map unchanged.
- CENTER state (1 cycle): if a box is at the centre tile, clear it, decrement box_count, and increment the accumulator. Then go to ARM with dir=UP and step=1.
- ARM state:
  - Processes one tile per cycle. Directions run in the order UP (row-1), DOWN (row+1), LEFT (col-1), RIGHT (col+1).
  - The ray ends when any of these occurs; the next direction then starts with step=1:
    - the target is off-grid (including 0-1 underflow): 1 cycle consumed, nothing written;
    - the target is a pillar: no clear;
    - the target holds a box: clear it, decrement box_count, increment the accumulator;
    - step equals the effective range, after processing the target.
  - An empty, non-pillar, on-grid tile continues to step+1.
  - After RIGHT finishes, go to DONE.
- DONE state (1 cycle): blast_done=1 and cleared_count=accumulator. Return to IDLE.
- Latency from accept to blast_done:
  - in-bounds centre: 1 (CENTER) + the sum of steps used in the four rays + 1 (DONE);
  - out-of-bounds centre: 1.
  - Maximum at default parameters is 1+12+1 = 14 cycles.
- Read port:
  - rd_box is the map bit at the address presented in the previous cycle; latency 1.
  - The read port is always active, including during INIT and blasts.
  - An out-of-range address returns 0.
  - A read of a tile cleared in the same cycle returns the old value; the next cycle returns 0.
- blast_req asserted while not ready: ignored. The requester must hold the request.
- Reset mid-blast or mid-INIT: abandons the operation, erases no further tiles from the old map, and restarts INIT from index 0. No blast_done is issued. Map contents are fully rewritten by INIT.
- box_count never underflows. It is a pure count of live box bits.

Test Plan:
- Reset, then wait → init_done rises exactly 165 cycles after reset deasserts. Read (2,0)→1, (3,0)→0, (1,1)→0 (pillar), (0,1)→0 (spawn). box_count equals the golden-model count.
- Blast at (3,0), range 2 → UP off-grid, DOWN (3,1) pillar, LEFT clears (2,0), RIGHT clears (4,0). blast_done occurs 6 cycles after accept, cleared_count=2, box_count drops by 2.
- Repeat the blast at (3,0), range 2 → LEFT (2,0),(1,0) empty. RIGHT (4,0) empty, then clears (5,0). cleared_count=1.
- Blast at col=15, row=0 → blast_done 1 cycle after accept, cleared_count=0, map unchanged.
- blast_range=0 at (3,0) on a fresh map → behaves as range 1, cleared_count=2.
- Assert reset 3 cycles into a blast → no blast_done, blast_ready=0, INIT reruns, and (2,0) reads 1 again after 165 cycles.
